can_data_dumper: RTL
====================

# can_data_dumper

Streams the contents of CanCore's data memory out as bytes once the core has halted. It is the read-back side of the data-memory port that preloads the core before `io_take`. It sits between CanCore's `io_dataMemory_read_*` port and a byte-wide valid/ready sink, such as a UART transmitter or a host FIFO. After `io_start` it reads every 512-bit word in address order and emits it least-significant byte first.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: data-memory address width.
- `DATA_WIDTH`, 512: data-memory word width. Must be a multiple of 8.
- `WORDS`, 16: number of words dumped, addresses 0..WORDS-1. Must satisfy WORDS ≤ 2^ADDR_WIDTH.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset. 0 = reset asserted.
- `io_halted`  in  1  core halted flag from CanCore.
- `io_start`  in  1  request to begin a dump, sampled each cycle.
- `io_dataMemory_read_addr`  out  ADDR_WIDTH  read address to CanCore data memory.
- `io_dataMemory_read_data`  in  DATA_WIDTH  synchronous read data, valid one cycle after the address.
- `io_out_valid`  out  1  byte available.
- `io_out_ready`  in  1  sink accepts the byte.
- `io_out_bits`  out  8  byte value.
- `io_busy`  out  1  dump in progress.
- `io_done`  out  1  one-cycle pulse after the final byte handshake.

## Operation
- FSM states: IDLE, FETCH, CAPTURE, SHIFT, DONE.
- IDLE
  - Sampling `io_start`=1 with `io_halted`=1 clears the word counter, drives address 0, and moves to FETCH.
  - `io_start` with `io_halted`=0 is ignored.
- FETCH: the address equals the word counter. Next state is CAPTURE.
- CAPTURE
  - The memory returns data for that address.
  - At the edge ending CAPTURE, `io_dataMemory_read_data` loads into a DATA_WIDTH shift register and the byte counter clears.
  - Next state is SHIFT.
- SHIFT
  - `io_out_valid`=1 and `io_out_bits` = shift register [7:0].
  - A handshake is `valid && ready` at a rising edge. On each handshake the register shifts right by 8 and the byte counter increments.
  - Handshake on byte DATA_WIDTH/8-1:
    - If the word counter = WORDS-1, go to DONE.
    - Otherwise increment the word counter and go to FETCH.
- DONE: `io_done`=1 for one cycle, then return to IDLE.
- `io_busy`=1 in FETCH, CAPTURE, SHIFT and DONE.
- `io_start` outside IDLE is ignored.
- `io_halted` falling mid-dump is ignored; the dump completes.
- Byte order: word 0 first; within a word, bits [7:0] first and [DATA_WIDTH-1:DATA_WIDTH-8] last.
- Counter widths:
  - Byte counter: clog2(DATA_WIDTH/8) bits. Its terminal value is compared explicitly, not by wrap-around.
  - Word counter: ADDR_WIDTH bits.

## Timing
- Reset values: `io_out_valid`=0, `io_out_bits`=0, `io_dataMemory_read_addr`=0, `io_busy`=0, `io_done`=0. FSM in IDLE, counters and shift register 0.
- Reset takes effect immediately, not at a clock edge; outputs go to reset values at once.
- Reset mid-dump abandons the dump. No partial state survives; the next accepted start begins at word 0, byte 0.
- Latency: with the edge sampling `io_start` as E0, FETCH spans E0–E1, CAPTURE spans E1–E2, and `io_out_valid` rises after E2.
- Per-word overhead: 2 non-valid cycles (FETCH, CAPTURE).
- With `io_out_ready` held at 1, a full dump takes WORDS×(DATA_WIDTH/8+2) cycles from E0 to the last handshake. At defaults this is 1056 cycles. `io_done` is high the following cycle.
- Valid/ready rules:
  - `io_out_bits` is stable while `valid && !ready`.
  - `io_out_valid` never drops without a handshake, except on reset.
  - There is no combinational path from `io_out_ready` to `io_out_valid` or `io_out_bits`.
- `io_dataMemory_read_addr` is registered. It holds its value through CAPTURE and SHIFT and changes only on entering FETCH or on reset.

## Structure
- Shared package `can_pkg` holds:
  - the data-memory geometry constants (address width 4, word width 512, word count 16);
  - the FSM state enum `dumper_state_t`.
- One natural sub-module, `can_word_serializer`: a parallel-load DATA_WIDTH→8 shift register with byte counter, load/shift controls and a last-byte flag.
- The FSM, word counter and address register stay in `can_data_dumper`.

## Test plan
- Reset: drive `reset`=0 mid-cycle → all outputs 0 immediately. Release with `io_start`=0 → outputs stay 0 and `io_busy`=0.
- Full dump, ready=1: memory word n byte b = (n·64+b) mod 256 → 1024 bytes observed as 0x00..0xFF repeated 4×. First valid 2 cycles after the start edge; `io_done` pulse exactly 1056 cycles after E0.
- Backpressure: random `io_out_ready` at 30% duty → same 1024-byte sequence with no loss or duplication. `io_out_bits` is constant across every stalled cycle.
- Start gating:
  - `io_start`=1 with `io_halted`=0 → stays IDLE and `io_busy`=0.
  - `io_start` pulsed during SHIFT of word 3 → no restart; the sequence continues at the next byte.
- Reset mid-dump: assert reset after byte 100 → valid drops at once. A new start emits byte 0x00 of word 0 first.
- Address check: `io_dataMemory_read_addr` steps 0,1,…,15, each changing only on entry to FETCH; word 15's last byte → DONE → IDLE.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CanCore data-memory geometry and dumper FSM encoding.
package can_pkg;

   localparam int CAN_ADDR_WIDTH = 4;
   localparam int CAN_DATA_WIDTH = 512;
   localparam int CAN_WORDS      = 16;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      SHIFT,
      DONE
   } dumper_state_t;

endpackage

// File: rtl/can_word_serializer.sv
// Parallel-load word register drained one byte at a time, LSB first.
module can_word_serializer
   import can_pkg::*;
#(
   parameter int DATA_WIDTH = CAN_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  shift,
   input  logic [DATA_WIDTH-1:0] loadData,
   output logic [7:0]            byteOut,
   output logic                  lastByte
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [DATA_WIDTH-1:0] sreg;
   logic [BCW-1:0]        byteCnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sreg    <= '0;
         byteCnt <= '0;
      end else if (load) begin
         sreg    <= loadData;
         byteCnt <= '0;
      end else if (shift) begin
         sreg    <= sreg >> 8;
         byteCnt <= lastByte ? '0 : byteCnt + 1'b1;
      end
   end

   assign byteOut  = sreg[7:0];
   assign lastByte = (byteCnt == BCW'(BYTES - 1));

endmodule

// File: rtl/can_data_dumper.sv
// Streams CanCore data memory out as bytes after the core halts.
module can_data_dumper
   import can_pkg::*;
#(
   parameter int ADDR_WIDTH = CAN_ADDR_WIDTH,
   parameter int DATA_WIDTH = CAN_DATA_WIDTH,
   parameter int WORDS      = CAN_WORDS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_halted,
   input  logic                  io_start,
   output logic [ADDR_WIDTH-1:0] io_dataMemory_read_addr,
   input  logic [DATA_WIDTH-1:0] io_dataMemory_read_data,
   output logic                  io_out_valid,
   input  logic                  io_out_ready,
   output logic [7:0]            io_out_bits,
   output logic                  io_busy,
   output logic                  io_done
);

   dumper_state_t         state;
   logic [ADDR_WIDTH-1:0] wordCnt;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  handshake;
   logic                  lastByte;
   logic [7:0]            byteOut;

   assign handshake = (state == SHIFT) && io_out_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         wordCnt <= '0;
         addr    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (io_start && io_halted) begin
                  wordCnt <= '0;
                  addr    <= '0;
                  state   <= FETCH;
               end
            end
            FETCH:   state <= CAPTURE;
            CAPTURE: state <= SHIFT;
            SHIFT: begin
               if (handshake && lastByte) begin
                  if (wordCnt == ADDR_WIDTH'(WORDS - 1)) begin
                     state <= DONE;
                  end else begin
                     wordCnt <= wordCnt + 1'b1;
                     addr    <= wordCnt + 1'b1;
                     state   <= FETCH;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   can_word_serializer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) ser (
      .clock   (clock),
      .reset   (reset),
      .load    (state == CAPTURE),
      .shift   (handshake),
      .loadData(io_dataMemory_read_data),
      .byteOut (byteOut),
      .lastByte(lastByte)
   );

   assign io_dataMemory_read_addr = addr;
   assign io_out_valid            = (state == SHIFT);
   assign io_out_bits             = byteOut;
   assign io_busy                 = (state != IDLE);
   assign io_done                 = (state == DONE);

endmodule
